// File: rtl/seven_seg_decoder.sv
// Receive-side 7-segment decoder: synchronises a..g/dp pins, filters glitches and recovers the hex digit.
// Optional saturating error counter is built when SEG_DECODE_ERRCNT_EN is defined.
module seven_seg_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned CNT_W          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  output logic [3:0] hex_out,
  output logic       dp_out,
  output logic       hex_valid,
  output logic       seg_err,
  output logic       blank,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    EVAL   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Returns {known, digit} for a {g..a} segment pattern.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [7:0]       sync1_r, sync2_r, p_prev_r, acc_pat_r;
  logic [CNT_W-1:0] cnt_r;
  logic             acc_vld_r;
  state_t           state_r, state_nxt_s;
  logic [7:0]       p_s;
  logic             changed_s, eval_s, new_pat_s, hit_s, blank_hit_s, err_hit_s;
  logic [4:0]       decode_s;
  logic [3:0]       hex_out_r;
  logic             dp_out_r, hex_valid_r, seg_err_r, blank_r;

  assign p_s       = SEG_ACTIVE_LOW ? ~sync2_r : sync2_r;
  assign changed_s = (p_s != p_prev_r);

  // Pin synchroniser, previous-sample register and stability counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_r  <= 8'h00;
      sync2_r  <= 8'h00;
      p_prev_r <= 8'h00;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      sync1_r  <= {dp_in, seg_in};
      sync2_r  <= sync1_r;
      p_prev_r <= p_s;
      // The first sample after reset starts a fresh run, like a pattern change.
      if (state_r == IDLE || changed_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; eval_s marks the edge entering EVAL so the registered results appear during EVAL.
  always_comb begin
    state_nxt_s = state_r;
    eval_s      = 1'b0;
    case (state_r)
      IDLE: state_nxt_s = TRACK;
      TRACK: begin
        if (changed_s) begin
          state_nxt_s = TRACK;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = EVAL;
          eval_s      = 1'b1;
        end else begin
          state_nxt_s = TRACK;
        end
      end
      EVAL: begin
        if (changed_s) begin
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      LOCKED: begin
        if (changed_s) begin
          state_nxt_s = TRACK;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Classify a newly stable pattern.
  always_comb begin
    decode_s    = glyph_decode(p_s[6:0]);
    new_pat_s   = eval_s && (!acc_vld_r || (p_s != acc_pat_r));
    hit_s       = new_pat_s && decode_s[4];
    blank_hit_s = new_pat_s && (p_s[6:0] == 7'h00);
    err_hit_s   = new_pat_s && !decode_s[4] && (p_s[6:0] != 7'h00);
  end

  // Accepted-pattern memory and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_pat_r   <= 8'h00;
      acc_vld_r   <= 1'b0;
      hex_out_r   <= 4'h0;
      dp_out_r    <= 1'b0;
      hex_valid_r <= 1'b0;
      seg_err_r   <= 1'b0;
      blank_r     <= 1'b0;
    end else begin
      hex_valid_r <= hit_s;
      seg_err_r   <= err_hit_s;
      if (new_pat_s) begin
        acc_pat_r <= p_s;
        acc_vld_r <= 1'b1;
      end else begin
        acc_pat_r <= acc_pat_r;
        acc_vld_r <= acc_vld_r;
      end
      if (hit_s) begin
        hex_out_r <= decode_s[3:0];
        dp_out_r  <= p_s[7];
        blank_r   <= 1'b0;
      end else if (blank_hit_s) begin
        dp_out_r  <= p_s[7];
        blank_r   <= 1'b1;
      end else begin
        hex_out_r <= hex_out_r;
        dp_out_r  <= dp_out_r;
        blank_r   <= blank_r;
      end
    end
  end

  assign hex_out   = hex_out_r;
  assign dp_out    = dp_out_r;
  assign hex_valid = hex_valid_r;
  assign seg_err   = seg_err_r;
  assign blank     = blank_r;

`ifdef SEG_DECODE_ERRCNT_EN
  logic [7:0] err_count_r;

  // Saturating count of unknown-glyph events, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_count_r <= 8'h00;
    end else if (err_hit_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'h01;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Self-checking bench for seven_seg_decoder (STABLE_CYCLES=4): directed scenarios plus random patterns
// checked every cycle against a behavioural stable-run model.
module tb_seven_seg_decoder;

  localparam int S = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG_DECODE_ERRCNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [3:0] hex_out;
  logic       dp_out, hex_valid, seg_err, blank;
  logic [7:0] err_count;

  always #5 CLK = ~CLK;

  seven_seg_decoder #(.STABLE_CYCLES(S), .CNT_W(16), .SEG_ACTIVE_LOW(1'b0)) dut (
    .CLK(CLK), .RST_N(RST_N), .seg_in(seg_in), .dp_in(dp_in),
    .hex_out(hex_out), .dp_out(dp_out), .hex_valid(hex_valid), .seg_err(seg_err),
    .blank(blank), .err_count(err_count)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int hv_seen, se_seen;

  // Reference model: pins reach the decoder two edges late; a pattern is accepted on the edge its
  // run of identical samples first reaches S+1, unless it equals the last accepted pattern.
  logic [7:0] m_d1, m_d2, m_run_val, m_acc;
  int         m_run_len;
  bit         m_first, m_vld;
  logic [3:0] m_hex;
  logic       m_dp, m_blank, m_hv, m_se;
  logic [7:0] m_ec;

  function automatic int glyph_index(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == seg) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [7:0] p;
    int idx;
    if (!RST_N) begin
      m_d1 = 8'h00; m_d2 = 8'h00; m_first = 1'b1; m_run_len = 0; m_run_val = 8'h00;
      m_acc = 8'h00; m_vld = 1'b0; m_hex = 4'h0; m_dp = 1'b0; m_blank = 1'b0;
      m_hv = 1'b0; m_se = 1'b0; m_ec = 8'h00;
    end else begin
      p    = m_d2;
      m_d2 = m_d1;
      m_d1 = {dp_in, seg_in};
      if (m_first || p != m_run_val) begin
        m_run_val = p; m_run_len = 1; m_first = 1'b0;
      end else if (m_run_len < S + 2) begin
        m_run_len++;
      end
      m_hv = 1'b0;
      m_se = 1'b0;
      if (m_run_len == S + 1 && (!m_vld || p != m_acc)) begin
        m_acc = p; m_vld = 1'b1;
        idx = glyph_index(p[6:0]);
        if (idx >= 0) begin
          m_hex = idx[3:0]; m_dp = p[7]; m_blank = 1'b0; m_hv = 1'b1;
        end else if (p[6:0] == 7'h00) begin
          m_blank = 1'b1; m_dp = p[7];
        end else begin
          m_se = 1'b1;
          if (EN && m_ec != 8'hFF) m_ec = m_ec + 8'h01;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance model at the edge, then compare every output 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("hex_out", {28'h0, hex_out}, {28'h0, m_hex});
    chk("dp_out", {31'h0, dp_out}, {31'h0, m_dp});
    chk("hex_valid", {31'h0, hex_valid}, {31'h0, m_hv});
    chk("seg_err", {31'h0, seg_err}, {31'h0, m_se});
    chk("blank", {31'h0, blank}, {31'h0, m_blank});
    chk("err_count", {24'h0, err_count}, {24'h0, m_ec});
    chk("pulse_excl", {31'h0, hex_valid & seg_err}, 32'h0);
    if (hex_valid === 1'b1) hv_seen++;
    if (seg_err === 1'b1) se_seen++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hv_idx;
    int hold;
    RST_N = 1'b0; seg_in = 7'h00; dp_in = 1'b0;
    hv_seen = 0; se_seen = 0;

    // 1: reset, then blank display acquired with no pulses
    steps(3);
    chk("rst_outputs", {hex_out, dp_out, hex_valid, seg_err, blank, err_count}, 32'h0);
    RST_N = 1'b1;
    steps(8);
    chk("t1_blank", {31'h0, blank}, 32'h1);
    chk("t1_pulses", hv_seen + se_seen, 32'd0);

    // 2: digit 2, exactly one pulse S+3 steps after the pins change
    hv_seen = 0; hv_idx = 0;
    seg_in = 7'h5B;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (hex_valid === 1'b1 && hv_idx == 0) hv_idx = i;
    end
    chk("t2_count", hv_seen, 32'd1);
    chk("t2_latency", hv_idx, S + 3);
    chk("t2_hex", {28'h0, hex_out}, 32'h2);
    chk("t2_blank", {31'h0, blank}, 32'h0);

    // 3: short bounce back to the accepted pattern
    hv_seen = 0; se_seen = 0;
    seg_in = 7'h4F; steps(2);
    seg_in = 7'h5B; steps(10);
    chk("t3_pulses", hv_seen + se_seen, 32'd0);
    chk("t3_hex", {28'h0, hex_out}, 32'h2);

    // 4: unknown glyph
    se_seen = 0; hv_seen = 0;
    seg_in = 7'h49; steps(10);
    chk("t4_err", se_seen, 32'd1);
    chk("t4_hv", hv_seen, 32'd0);
    chk("t4_hex", {28'h0, hex_out}, 32'h2);
    chk("t4_errcnt", {24'h0, err_count}, EN ? 32'd1 : 32'd0);

    // 5: dp-only changes are new patterns
    hv_seen = 0;
    seg_in = 7'h7F;
    for (int t = 0; t < 6; t++) begin
      dp_in = t[0];
      steps(8);
      chk("t5_dp", {31'h0, dp_out}, {31'h0, t[0]});
      chk("t5_hex", {28'h0, hex_out}, 32'h8);
    end
    chk("t5_count", hv_seen, 32'd6);

    // 6: reset while filtering, then re-acquire
    hv_seen = 0; dp_in = 1'b0;
    seg_in = 7'h77; steps(5);
    RST_N = 1'b0; steps(2);
    chk("t6_no_hv", hv_seen, 32'd0);
    chk("t6_rst_hex", {28'h0, hex_out}, 32'h0);
    RST_N = 1'b1; steps(12);
    chk("t6_hv", hv_seen, 32'd1);
    chk("t6_hex", {28'h0, hex_out}, 32'hA);

    // 7: 300 alternating invalid patterns
    se_seen = 0;
    for (int t = 0; t < 300; t++) begin
      seg_in = t[0] ? 7'h36 : 7'h49;
      steps(7);
    end
    chk("t7_err", se_seen, 32'd300);
    chk("t7_errcnt", {24'h0, err_count}, EN ? 32'hFF : 32'h0);

    // Random patterns, hold times and occasional resets
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: seg_in = GLYPH[$urandom_range(0, 15)];
        5:             seg_in = 7'h00;
        6:             seg_in = 7'($urandom);
        7:             dp_in  = ~dp_in;
        default:       seg_in = (($urandom_range(0, 1) == 0) ? 7'h49 : 7'h36);
      endcase
      if ($urandom_range(0, 3) == 0) dp_in = 1'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        RST_N = 1'b0; steps(2); RST_N = 1'b1;
      end
      hold = $urandom_range(1, 10);
      steps(hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
